// File: rtl/regfile_pkg.sv
// Shared constants and types for the register file.
// The byte-lane count derives from the word width.
package regfile_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 32;
    localparam int unsigned DEFAULT_DEPTH      = 32;
    localparam int unsigned BYTES_PER_WORD     = DEFAULT_DATA_WIDTH / 8;

    typedef logic [7:0] byte_t;

    function automatic int unsigned bytes_per_word(input int unsigned width);
        return width / 8;
    endfunction

endpackage

// File: rtl/register_n_bits.sv
// N-bit storage element with load enable.
// It clears asynchronously while the active-low reset is held.
module register_n_bits #(
    parameter int unsigned N = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         write_enable_i,
    input  logic [N-1:0] data_i,
    output logic [N-1:0] data_o
);

    logic [N-1:0] data_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            data_q <= '0;
        end else if (write_enable_i) begin
            data_q <= data_i;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/register_file_n_bits.sv
// Multi-entry register file: two combinational read ports and one byte-masked write port.
// Entry 0 can be hardwired to zero, and same-cycle write data can be bypassed to the reads.
module register_file_n_bits
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned DEPTH      = DEFAULT_DEPTH,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
    parameter bit          ZERO_REG   = 1'b1,
    parameter bit          BYPASS     = 1'b0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    write_enable_i,
    input  logic [DATA_WIDTH/8-1:0] byte_enable_i,
    input  logic [ADDR_WIDTH-1:0]   write_addr_i,
    input  logic [DATA_WIDTH-1:0]   write_data_i,
    input  logic [ADDR_WIDTH-1:0]   read_addr1_i,
    output logic [DATA_WIDTH-1:0]   read_data1_o,
    input  logic [ADDR_WIDTH-1:0]   read_addr2_i,
    output logic [DATA_WIDTH-1:0]   read_data2_o
);

    localparam int unsigned NumBytes = bytes_per_word(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] entry_q [DEPTH];
    logic                  wr_active;

    // Writes are ignored while reset is held, which also keeps the bypass path quiet.
    assign wr_active = write_enable_i & rst_i;

    for (genvar e = 0; e < DEPTH; e++) begin : g_entry
        if (ZERO_REG && (e == 0)) begin : g_zero
            assign entry_q[e] = '0;
        end else begin : g_store
            logic                     addr_hit;
            byte_t [NumBytes-1:0]     bytes_q;

            assign addr_hit = wr_active && (write_addr_i == ADDR_WIDTH'(e));

            for (genvar k = 0; k < NumBytes; k++) begin : g_byte
                register_n_bits #(
                    .N (8)
                ) u_byte (
                    .clk_i          (clk_i),
                    .rst_i          (rst_i),
                    .write_enable_i (addr_hit & byte_enable_i[k]),
                    .data_i         (write_data_i[8*k +: 8]),
                    .data_o         (bytes_q[k])
                );
            end

            assign entry_q[e] = bytes_q;
        end
    end

    logic [DATA_WIDTH-1:0] merged;
    logic                  bypass_hit1;
    logic                  bypass_hit2;

    always_comb begin
        merged = entry_q[write_addr_i];
        for (int k = 0; k < NumBytes; k++) begin
            if (byte_enable_i[k]) begin
                merged[8*k +: 8] = write_data_i[8*k +: 8];
            end
        end

        // A hardwired zero entry never takes the bypass path.
        bypass_hit1 = BYPASS && wr_active && (read_addr1_i == write_addr_i)
                      && !(ZERO_REG && (read_addr1_i == '0));
        bypass_hit2 = BYPASS && wr_active && (read_addr2_i == write_addr_i)
                      && !(ZERO_REG && (read_addr2_i == '0));

        read_data1_o = bypass_hit1 ? merged : entry_q[read_addr1_i];
        read_data2_o = bypass_hit2 ? merged : entry_q[read_addr2_i];
    end

endmodule

// File: tb/tb_register_file_n_bits.sv
// Directed bench for the register file across three configurations:
// a = zero reg/no bypass, b = no zero reg/bypass, c = zero reg/bypass.
module tb_register_file_n_bits;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  be = 4'h0;
    logic [4:0]  wa = 5'd0;
    logic [31:0] wd = 32'd0;
    logic [4:0]  ra1 = 5'd0;
    logic [4:0]  ra2 = 5'd0;
    logic [31:0] r1_a, r2_a, r1_b, r2_b, r1_c, r2_c;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    register_file_n_bits #(.ZERO_REG(1'b1), .BYPASS(1'b0)) dut_a (
        .clk_i(clk), .rst_i(rst), .write_enable_i(we), .byte_enable_i(be),
        .write_addr_i(wa), .write_data_i(wd), .read_addr1_i(ra1), .read_data1_o(r1_a),
        .read_addr2_i(ra2), .read_data2_o(r2_a)
    );

    register_file_n_bits #(.ZERO_REG(1'b0), .BYPASS(1'b1)) dut_b (
        .clk_i(clk), .rst_i(rst), .write_enable_i(we), .byte_enable_i(be),
        .write_addr_i(wa), .write_data_i(wd), .read_addr1_i(ra1), .read_data1_o(r1_b),
        .read_addr2_i(ra2), .read_data2_o(r2_b)
    );

    register_file_n_bits #(.ZERO_REG(1'b1), .BYPASS(1'b1)) dut_c (
        .clk_i(clk), .rst_i(rst), .write_enable_i(we), .byte_enable_i(be),
        .write_addr_i(wa), .write_data_i(wd), .read_addr1_i(ra1), .read_data1_o(r1_c),
        .read_addr2_i(ra2), .read_data2_o(r2_c)
    );

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    initial begin
        vecs[0] = '{1'b1, 4'hF, 5'd7,  32'hFEDCBA98, 5'd7,  5'd7,  32'hFEDCBA98, 32'hFEDCBA98};
        vecs[1] = '{1'b1, 4'hF, 5'd3,  32'h11111111, 5'd3,  5'd7,  32'h11111111, 32'hFEDCBA98};
        vecs[2] = '{1'b1, 4'h5, 5'd3,  32'hAABBCCDD, 5'd3,  5'd3,  32'h11BB11DD, 32'h11BB11DD};
        vecs[3] = '{1'b1, 4'h0, 5'd3,  32'hFFFFFFFF, 5'd3,  5'd7,  32'h11BB11DD, 32'hFEDCBA98};
        vecs[4] = '{1'b0, 4'hF, 5'd9,  32'h01010101, 5'd9,  5'd3,  32'h00000000, 32'h11BB11DD};
        vecs[5] = '{1'b1, 4'h8, 5'd12, 32'hA5A5A5A5, 5'd12, 5'd7,  32'hA5000000, 32'hFEDCBA98};
        vecs[6] = '{1'b1, 4'h2, 5'd12, 32'h00003C00, 5'd12, 5'd9,  32'hA5003C00, 32'h00000000};
        vecs[7] = '{1'b1, 4'hF, 5'd31, 32'hDEADBEEF, 5'd31, 5'd12, 32'hDEADBEEF, 32'hA5003C00};

        // Reset held from time 0: all reads are zero.
        ra1 = 5'd0;
        ra2 = 5'd31;
        #2;
        check("reset_r1_b", r1_b, 32'd0);
        check("reset_r2_a", r2_a, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            we  = vecs[i].we;
            be  = vecs[i].be;
            wa  = vecs[i].wa;
            wd  = vecs[i].wd;
            ra1 = vecs[i].ra1;
            ra2 = vecs[i].ra2;
            @(posedge clk);
            #1 we = 1'b0;
            #1;
            check($sformatf("vec%0d_r1_a", i), r1_a, vecs[i].exp1);
            check($sformatf("vec%0d_r2_a", i), r2_a, vecs[i].exp2);
            check($sformatf("vec%0d_r1_b", i), r1_b, vecs[i].exp1);
            check($sformatf("vec%0d_r2_c", i), r2_c, vecs[i].exp2);
        end

        // Same-cycle write and read of entry 4 (holding 0).
        @(negedge clk);
        we = 1'b1; be = 4'hF; wa = 5'd4; wd = 32'hCAFEF00D; ra1 = 5'd4; ra2 = 5'd4;
        #1;
        check("byp_pre_a", r1_a, 32'h00000000);
        check("byp_pre_b", r1_b, 32'hCAFEF00D);
        check("byp_pre_c", r2_c, 32'hCAFEF00D);
        @(posedge clk);
        #1;
        check("byp_post_a", r1_a, 32'hCAFEF00D);

        // Partial-byte bypass merges with stored value.
        @(negedge clk);
        we = 1'b1; be = 4'h3; wa = 5'd4; wd = 32'h12345678;
        #1;
        check("byp_part_a", r1_a, 32'hCAFEF00D);
        check("byp_part_b", r1_b, 32'hCAFE5678);
        @(posedge clk);
        #1 we = 1'b0;
        #1;
        check("byp_part_post_a", r2_a, 32'hCAFE5678);

        // Entry 0: discarded when hardwired, stored otherwise; zero wins over bypass.
        @(negedge clk);
        we = 1'b1; be = 4'hF; wa = 5'd0; wd = 32'hFFFFFFFF; ra1 = 5'd0; ra2 = 5'd0;
        #1;
        check("zero_byp_c", r1_c, 32'd0);
        check("zero_byp_b", r1_b, 32'hFFFFFFFF);
        @(posedge clk);
        #1 we = 1'b0;
        #1;
        check("zero_post_a", r1_a, 32'd0);
        check("zero_post_b", r2_b, 32'hFFFFFFFF);
        check("zero_post_c", r2_c, 32'd0);

        // Asynchronous reset mid-cycle clears contents before the next edge.
        @(negedge clk);
        we = 1'b1; be = 4'hF; wa = 5'd5; wd = 32'h12345678;
        @(posedge clk);
        #1 we = 1'b0; ra1 = 5'd5; ra2 = 5'd7;
        #1;
        check("pre_rst_a", r1_a, 32'h12345678);
        #1 rst = 1'b0;
        #1;
        check("mid_rst_a", r1_a, 32'd0);
        check("mid_rst_b", r1_b, 32'd0);
        check("mid_rst_r2_c", r2_c, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("post_rst_a", r1_a, 32'd0);
        check("post_rst_b0", r2_b, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
